fishing_game_ctrl: RTL and testbench
====================================

FISHING_GAME_CTRL -- requirements
Module: fishing_game_ctrl

Interface
REQ-001 Parameter NUM_LEVELS, default 4: number of fish to land before a win (1..8).
REQ-002 Parameter FISH_Y0, default 470: level-0 fish centre row; LEVEL_DY, default 90: rise per level.
REQ-003 Parameter FISH_W0, default 60, and FISH_H0, default 10: level-0 fish width and half-height.
REQ-004 Parameters FISH_SPEED 2, LINE_SPEED 4, REEL_SPEED 2, ROD_STEP 3: pixels moved per clk.
REQ-005 Parameters SURFACE_Y 155, CATCH_Y 105, ROD_MIN 312, H_MIN 144, H_MAX 798: screen bounds.
REQ-006 clk  in  1  slow game clock; one game update per rising edge.
REQ-007 rst  in  1  one clock; reset is synchronous and active-high.
REQ-008 bright  in  1  high inside visible display area.
REQ-009 up, down, left, right  in  1 each  player buttons, already debounced and synchronous to clk.
REQ-010 hCount, vCount  in  10 each  current pixel coordinates.
REQ-011 rgb  out  12  combinational pixel colour, 4 bits per channel, R in [11:8].
REQ-012 level  out  $clog2(NUM_LEVELS+1)  registered count of fish landed.
REQ-013 won  out  1  registered, high exactly while in state WIN.

Function
REQ-014 States SWIM, REEL, WIN; registers rpos (rod x), ypos (hook y), fpos (fish left x), fypos (fish centre y), all 10 bits unsigned.
REQ-015 Per level L: fish_y = FISH_Y0 - L*LEVEL_DY; half_h = max(FISH_H0>>L, 1); fish_w = max(FISH_W0>>L, 4).
REQ-016 SWIM: fpos -= FISH_SPEED; if fpos <= H_MIN + FISH_SPEED then fpos = H_MAX next cycle (wrap, never underflows).
REQ-017 SWIM: fypos held at fish_y; ypos += LINE_SPEED clamped to fish_y; ypos above... never exceeds fish_y.
REQ-018 SWIM: right has priority over left; rpos += ROD_STEP clamped to H_MAX; rpos -= ROD_STEP clamped to ROD_MIN.
REQ-019 SWIM -> REEL when up and fpos <= rpos <= fpos+fish_w/4 and |ypos - fypos| <= half_h, evaluated on pre-update values; rod/fish do not move that cycle.
REQ-020 REEL: fpos = rpos each cycle; with up, fypos and ypos each decrease REEL_SPEED; rod frozen.
REQ-021 REEL with down (down wins over up): fish escapes -> SWIM, fpos = H_MAX, fypos = fish_y, level unchanged.
REQ-022 REEL when fypos <= CATCH_Y: level += 1; if new level == NUM_LEVELS -> WIN, else SWIM with fpos = H_MAX, fypos and ypos at new fish_y.
REQ-023 WIN: all positions frozen; left or right -> SWIM with level = 0 and all registers at reset values except rpos.
REQ-024 Colour priority: ~bright black; buoy brown 12'h621; angler red 12'hF00; fish orange 12'hE94 (not in WIN); rod/jut/line green 12'h0F0; sun yellow 12'hFF0 (WIN only, box h 720..760, v 55..95); vCount >= SURFACE_Y blue 12'h00F; else white.
REQ-025 Sprite boxes relative to rpos (h offsets, v range): head -120..-100, 75..85; torso -140..-80, 85..115; arms -160..-140 and -80..-60, 85..125; legs -140..-120 and -100..-80, 115..155; buoy -150..-70, 145..155, floats -170..-150 and -70..-50, 135..155; rod -60..-50, 75..125; jut -50..-5, 75..80; line -5..0, 75..ypos.
REQ-026 Fish box: hCount fpos..fpos+fish_w, vCount fypos-half_h..fypos+half_h, all bounds inclusive.

Reset
REQ-027 On rst at clk edge: state SWIM, rpos 450, ypos SURFACE_Y, fpos H_MAX, fypos FISH_Y0, level 0, won 0; rst overrides all button inputs.
REQ-028 rst mid-REEL or mid-WIN returns to the REQ-027 values in one cycle; rgb reflects them the same cycle after.

Verification
REQ-029 rst 1 cycle, no buttons, 10 clks -> fpos 778, ypos 195, state SWIM, level 0.
REQ-030 Hold right 200 clks -> rpos saturates at 798, never exceeds; hold left and right together -> rpos increases.
REQ-031 Fish fpos 146 in SWIM -> next clk fpos 798; no value below 144 ever observed.
REQ-032 Align rpos=fpos, ypos=470, press up -> REEL next clk; hold up 183 clks -> level 1, fypos 380, state SWIM.
REQ-033 In REEL press up and down together -> SWIM, fpos 798, level unchanged.
REQ-034 NUM_LEVELS=2: land two fish -> won 1, sun pixel (740,75) yellow, fish pixels not orange; press left -> level 0, won 0.

Source files
------------

// File: rtl/fishing_game_ctrl.sv
// Fishing game controller: angler rod/line, swimming fish, reel-in and win logic,
// plus the combinational pixel colour generator for the playfield.
module fishing_game_ctrl #(
   parameter int NUM_LEVELS = 4,
   parameter int FISH_Y0    = 470,
   parameter int LEVEL_DY   = 90,
   parameter int FISH_W0    = 60,
   parameter int FISH_H0    = 10,
   parameter int FISH_SPEED = 2,
   parameter int LINE_SPEED = 4,
   parameter int REEL_SPEED = 2,
   parameter int ROD_STEP   = 3,
   parameter int SURFACE_Y  = 155,
   parameter int CATCH_Y    = 105,
   parameter int ROD_MIN    = 312,
   parameter int H_MIN      = 144,
   parameter int H_MAX      = 798,
   localparam int unsigned LW = $clog2(NUM_LEVELS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          bright,
   input  logic          up,
   input  logic          down,
   input  logic          left,
   input  logic          right,
   input  logic [9:0]    hCount,
   input  logic [9:0]    vCount,
   output logic [11:0]   rgb,
   output logic [LW-1:0] level,
   output logic          won
);

   localparam logic [9:0] C_HMAX    = 10'(H_MAX);
   localparam logic [9:0] C_WRAP    = 10'(H_MIN + FISH_SPEED);
   localparam logic [9:0] C_RODMIN  = 10'(ROD_MIN);
   localparam logic [9:0] C_RODLOW  = 10'(ROD_MIN + ROD_STEP);
   localparam logic [9:0] C_SURF    = 10'(SURFACE_Y);
   localparam logic [9:0] C_CATCH   = 10'(CATCH_Y);
   localparam logic [9:0] C_FY0     = 10'(FISH_Y0);
   localparam logic [9:0] C_ROD_RST = 10'd450;

   typedef enum logic [1:0] {S_SWIM, S_REEL, S_WIN} state_t;

   state_t        r_state, w_state_nxt;
   logic [9:0]    r_rpos, r_ypos, r_fpos, r_fypos;
   logic [9:0]    w_rpos_nxt, w_ypos_nxt, w_fpos_nxt, w_fypos_nxt;
   logic [LW-1:0] r_level, w_level_nxt, w_level_inc;
   logic          r_won, w_won_nxt;

   logic [9:0]  w_fish_y, w_fish_y_up, w_half_h, w_fish_w, w_ydiff, w_fy_dec;
   logic [10:0] w_ypos_inc, w_rod_inc, w_catch_hi;
   logic        w_aligned;

   function automatic logic [9:0] fish_y_of(input int lvl);
      return 10'(FISH_Y0 - LEVEL_DY * lvl);
   endfunction

   // Per-level fish geometry: shrinks with each level, floored at a visible minimum
   assign w_fish_y    = fish_y_of(int'(r_level));
   assign w_fish_y_up = fish_y_of(int'(r_level) + 1);
   assign w_half_h    = ((FISH_H0 >> r_level) < 1) ? 10'd1 : 10'(FISH_H0 >> r_level);
   assign w_fish_w    = ((FISH_W0 >> r_level) < 4) ? 10'd4 : 10'(FISH_W0 >> r_level);

   assign w_ypos_inc  = 11'(r_ypos) + 11'(LINE_SPEED);
   assign w_rod_inc   = 11'(r_rpos) + 11'(ROD_STEP);
   assign w_catch_hi  = 11'(r_fpos) + 11'(w_fish_w >> 2);
   assign w_ydiff     = (r_ypos >= r_fypos) ? (r_ypos - r_fypos) : (r_fypos - r_ypos);
   assign w_aligned   = (r_fpos <= r_rpos) && (11'(r_rpos) <= w_catch_hi) && (w_ydiff <= w_half_h);
   assign w_fy_dec    = r_fypos - 10'(REEL_SPEED);
   assign w_level_inc = r_level + LW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_SWIM;
         r_rpos  <= C_ROD_RST;
         r_ypos  <= C_SURF;
         r_fpos  <= C_HMAX;
         r_fypos <= C_FY0;
         r_level <= '0;
         r_won   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rpos  <= w_rpos_nxt;
         r_ypos  <= w_ypos_nxt;
         r_fpos  <= w_fpos_nxt;
         r_fypos <= w_fypos_nxt;
         r_level <= w_level_nxt;
         r_won   <= w_won_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rpos_nxt  = r_rpos;
      w_ypos_nxt  = r_ypos;
      w_fpos_nxt  = r_fpos;
      w_fypos_nxt = r_fypos;
      w_level_nxt = r_level;
      case (r_state)
         S_SWIM: begin
            // A hook is decided on pre-move positions; nothing moves on that cycle
            if (up && w_aligned) begin
               w_state_nxt = S_REEL;
            end else begin
               w_fpos_nxt  = (r_fpos <= C_WRAP) ? C_HMAX : r_fpos - 10'(FISH_SPEED);
               w_fypos_nxt = w_fish_y;
               w_ypos_nxt  = (w_ypos_inc >= 11'(w_fish_y)) ? w_fish_y : w_ypos_inc[9:0];
               if (right)
                  w_rpos_nxt = (w_rod_inc >= 11'(H_MAX)) ? C_HMAX : w_rod_inc[9:0];
               else if (left)
                  w_rpos_nxt = (r_rpos <= C_RODLOW) ? C_RODMIN : r_rpos - 10'(ROD_STEP);
            end
         end
         S_REEL: begin
            w_fpos_nxt = r_rpos;
            if (down) begin
               w_state_nxt = S_SWIM;
               w_fpos_nxt  = C_HMAX;
               w_fypos_nxt = w_fish_y;
            end else if (up) begin
               w_fypos_nxt = w_fy_dec;
               w_ypos_nxt  = r_ypos - 10'(REEL_SPEED);
               if (w_fy_dec <= C_CATCH) begin
                  w_level_nxt = w_level_inc;
                  if (int'(w_level_inc) == NUM_LEVELS) begin
                     w_state_nxt = S_WIN;
                  end else begin
                     w_state_nxt = S_SWIM;
                     w_fpos_nxt  = C_HMAX;
                     w_fypos_nxt = w_fish_y_up;
                     w_ypos_nxt  = w_fish_y_up;
                  end
               end
            end
         end
         S_WIN: begin
            if (left || right) begin
               w_state_nxt = S_SWIM;
               w_level_nxt = '0;
               w_ypos_nxt  = C_SURF;
               w_fpos_nxt  = C_HMAX;
               w_fypos_nxt = C_FY0;
            end
         end
         default: w_state_nxt = S_SWIM;
      endcase
      w_won_nxt = (w_state_nxt == S_WIN);
   end

   assign level = r_level;
   assign won   = r_won;

   // Sprite boxes are inclusive horizontal offsets to the left of the rod x position
   function automatic logic rel(input logic [10:0] h, input logic [10:0] r, input int lo, input int hi);
      return ((h + 11'(hi)) <= r) && (r <= (h + 11'(lo)));
   endfunction

   function automatic logic vin(input logic [9:0] v, input int lo, input int hi);
      return (v >= 10'(lo)) && (v <= 10'(hi));
   endfunction

   logic [10:0] w_h, w_r;
   logic        w_buoy, w_angler, w_fish, w_green, w_sun;

   assign w_h = 11'(hCount);
   assign w_r = 11'(r_rpos);

   assign w_buoy   = (rel(w_h, w_r, 150, 70)  && vin(vCount, 145, 155)) ||
                     (rel(w_h, w_r, 170, 150) && vin(vCount, 135, 155)) ||
                     (rel(w_h, w_r, 70, 50)   && vin(vCount, 135, 155));
   assign w_angler = (rel(w_h, w_r, 120, 100) && vin(vCount, 75, 85))   ||
                     (rel(w_h, w_r, 140, 80)  && vin(vCount, 85, 115))  ||
                     (rel(w_h, w_r, 160, 140) && vin(vCount, 85, 125))  ||
                     (rel(w_h, w_r, 80, 60)   && vin(vCount, 85, 125))  ||
                     (rel(w_h, w_r, 140, 120) && vin(vCount, 115, 155)) ||
                     (rel(w_h, w_r, 100, 80)  && vin(vCount, 115, 155));
   assign w_fish   = (r_state != S_WIN) &&
                     (w_h >= 11'(r_fpos)) && (w_h <= 11'(r_fpos) + 11'(w_fish_w)) &&
                     ((11'(vCount) + 11'(w_half_h)) >= 11'(r_fypos)) &&
                     (11'(vCount) <= (11'(r_fypos) + 11'(w_half_h)));
   assign w_green  = (rel(w_h, w_r, 60, 50) && vin(vCount, 75, 125)) ||
                     (rel(w_h, w_r, 50, 5)  && vin(vCount, 75, 80))  ||
                     (rel(w_h, w_r, 5, 0)   && (vCount >= 10'd75) && (vCount <= r_ypos));
   assign w_sun    = (r_state == S_WIN) && (hCount >= 10'd720) && (hCount <= 10'd760) &&
                     vin(vCount, 55, 95);

   always_comb begin
      rgb = 12'hFFF;
      if (!bright)               rgb = 12'h000;
      else if (w_buoy)           rgb = 12'h621;
      else if (w_angler)         rgb = 12'hF00;
      else if (w_fish)           rgb = 12'hE94;
      else if (w_green)          rgb = 12'h0F0;
      else if (w_sun)            rgb = 12'hFF0;
      else if (vCount >= C_SURF) rgb = 12'h00F;
   end

endmodule

// File: tb/tb_fishing_game_ctrl.sv
// Directed bench for fishing_game_ctrl (two-level game): movement, hooking,
// reeling, escape, win, rod/fish bounds, reset mid-reel and pixel colours.
module tb_fishing_game_ctrl;

   logic        clk = 1'b0;
   logic        rst, bright, up, down, left, right;
   logic [9:0]  hCount, vCount;
   logic [11:0] rgb;
   logic [1:0]  level;
   logic        won;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int fmin   = 1023;
   int rmax   = 0;
   bit mon_en = 1'b0;

   localparam logic [31:0] ST_SWIM = 32'd0;
   localparam logic [31:0] ST_REEL = 32'd1;
   localparam logic [31:0] ST_WIN  = 32'd2;

   fishing_game_ctrl #(.NUM_LEVELS(2)) dut (
      .clk(clk), .rst(rst), .bright(bright),
      .up(up), .down(down), .left(left), .right(right),
      .hCount(hCount), .vCount(vCount),
      .rgb(rgb), .level(level), .won(won)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (mon_en && int'(dut.r_fpos) < fmin) fmin = int'(dut.r_fpos);

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pix(input string tag, input int h, input int v, input logic [11:0] exp);
      hCount = 10'(h);
      vCount = 10'(v);
      #1;
      chk(tag, 32'(rgb), 32'(exp));
   endtask

   initial begin
      rst = 1'b1; bright = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
      hCount = '0; vCount = '0;

      // Reset values and static playfield colours
      tick(1);
      rst = 1'b0;
      chk("rst_state", 32'(dut.r_state), ST_SWIM);
      chk("rst_rpos",  32'(dut.r_rpos), 32'd450);
      chk("rst_ypos",  32'(dut.r_ypos), 32'd155);
      chk("rst_fpos",  32'(dut.r_fpos), 32'd798);
      chk("rst_fypos", 32'(dut.r_fypos), 32'd470);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_won",   32'(won), 32'd0);
      bright = 1'b0;
      pix("pix_dark", 340, 80, 12'h000);
      bright = 1'b1;
      pix("pix_head",  340, 80,  12'hF00);
      pix("pix_buoy",  340, 150, 12'h621);
      pix("pix_line",  448, 100, 12'h0F0);
      pix("pix_water", 600, 300, 12'h00F);
      pix("pix_sky",   600, 50,  12'hFFF);

      // Idle swim for 10 clocks
      tick(10);
      chk("idle_fpos",  32'(dut.r_fpos), 32'd778);
      chk("idle_ypos",  32'(dut.r_ypos), 32'd195);
      chk("idle_state", 32'(dut.r_state), ST_SWIM);
      chk("idle_level", 32'(level), 32'd0);
      pix("pix_fish0", 780, 470, 12'hE94);
      pix("pix_rod",   395, 100, 12'h0F0);

      // Fish reaches the rod at t=174, line already down at 470
      tick(164);
      chk("align_fpos", 32'(dut.r_fpos), 32'd450);
      chk("align_ypos", 32'(dut.r_ypos), 32'd470);
      up = 1'b1;
      tick(1);
      chk("hook_state", 32'(dut.r_state), ST_REEL);
      chk("hook_fpos",  32'(dut.r_fpos), 32'd450);
      tick(183);
      up = 1'b0;
      chk("land1_level", 32'(level), 32'd1);
      chk("land1_fypos", 32'(dut.r_fypos), 32'd380);
      chk("land1_ypos",  32'(dut.r_ypos), 32'd380);
      chk("land1_fpos",  32'(dut.r_fpos), 32'd798);
      chk("land1_state", 32'(dut.r_state), ST_SWIM);

      // Hook level-1 fish then let it escape with up+down
      tick(174);
      chk("align2_fpos", 32'(dut.r_fpos), 32'd450);
      up = 1'b1;
      tick(1);
      chk("hook2_state", 32'(dut.r_state), ST_REEL);
      tick(3);
      chk("reel2_fypos", 32'(dut.r_fypos), 32'd374);
      down = 1'b1;
      tick(1);
      up = 1'b0; down = 1'b0;
      chk("esc_state", 32'(dut.r_state), ST_SWIM);
      chk("esc_fpos",  32'(dut.r_fpos), 32'd798);
      chk("esc_fypos", 32'(dut.r_fypos), 32'd380);
      chk("esc_level", 32'(level), 32'd1);

      // Land the second fish: 138 reel clocks from fypos 380 wins the game
      tick(174);
      chk("align3_fpos", 32'(dut.r_fpos), 32'd450);
      chk("align3_ypos", 32'(dut.r_ypos), 32'd380);
      up = 1'b1;
      tick(1);
      chk("hook3_state", 32'(dut.r_state), ST_REEL);
      tick(137);
      chk("reel3_state", 32'(dut.r_state), ST_REEL);
      chk("reel3_fypos", 32'(dut.r_fypos), 32'd106);
      tick(1);
      up = 1'b0;
      chk("win_state", 32'(dut.r_state), ST_WIN);
      chk("win_won",   32'(won), 32'd1);
      chk("win_level", 32'(level), 32'd2);
      pix("pix_sun",      740, 75,  12'hFF0);
      pix("pix_nofish",   470, 104, 12'hFFF);
      down = 1'b1;
      tick(5);
      down = 1'b0;
      chk("win_hold_state", 32'(dut.r_state), ST_WIN);
      chk("win_hold_rpos",  32'(dut.r_rpos), 32'd450);
      chk("win_hold_won",   32'(won), 32'd1);
      left = 1'b1;
      tick(1);
      left = 1'b0;
      chk("exit_state", 32'(dut.r_state), ST_SWIM);
      chk("exit_level", 32'(level), 32'd0);
      chk("exit_won",   32'(won), 32'd0);
      chk("exit_fpos",  32'(dut.r_fpos), 32'd798);
      chk("exit_ypos",  32'(dut.r_ypos), 32'd155);
      chk("exit_fypos", 32'(dut.r_fypos), 32'd470);
      chk("exit_rpos",  32'(dut.r_rpos), 32'd450);

      // Rod movement: right beats left, saturation at both ends
      left = 1'b1; right = 1'b1;
      tick(1);
      left = 1'b0;
      chk("rod_both", 32'(dut.r_rpos), 32'd453);
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (int'(dut.r_rpos) > rmax) rmax = int'(dut.r_rpos);
      end
      right = 1'b0;
      chk("rod_max_seen", 32'(rmax), 32'd798);
      chk("rod_right",    32'(dut.r_rpos), 32'd798);
      left = 1'b1;
      tick(200);
      left = 1'b0;
      chk("rod_left", 32'(dut.r_rpos), 32'd312);

      // Fish wrap at the left edge
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      mon_en = 1'b1;
      tick(326);
      chk("wrap_pre",  32'(dut.r_fpos), 32'd146);
      tick(1);
      chk("wrap_post", 32'(dut.r_fpos), 32'd798);
      mon_en = 1'b0;
      chk("wrap_min",  32'(fmin), 32'd146);

      // Reset while reeling with up held
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(174);
      up = 1'b1;
      tick(1);
      chk("hook4_state", 32'(dut.r_state), ST_REEL);
      tick(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0; up = 1'b0;
      chk("rreel_state", 32'(dut.r_state), ST_SWIM);
      chk("rreel_fpos",  32'(dut.r_fpos), 32'd798);
      chk("rreel_fypos", 32'(dut.r_fypos), 32'd470);
      chk("rreel_ypos",  32'(dut.r_ypos), 32'd155);
      chk("rreel_level", 32'(level), 32'd0);
      pix("pix_rreel_fish", 800, 470, 12'hE94);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
